rooth_bus_arb: RTL and testbench

ROOTH_BUS_ARB -- requirements
Module: rooth_bus_arb

---
 rtl/rooth_bus_arb.sv | 245 ++++++++++++++++++++++++
 tb/tb_rooth_bus_arb.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rooth_bus_arb.sv
// -----------------------------------------------------------------------------
// rooth_bus_arb
//
// Three-master to one-slave bus arbiter. Master 0 is the JTAG debug port,
// master 1 the core data port and master 2 the DMA/peripheral port. An access
// moves through three phases:
//   IDLE   - pick a winner round-robin, latch its request fields
//   ACCESS - drive the slave with the latched fields until s_ack
//   RESP   - return the registered read data to the winner for one cycle
// Only one access is in flight at a time, so m_rdata/m_err are shared and
// qualified by the one-hot m_rvalid.
//
// Parameters
//   DW           data and address width in bits
//   TIMEOUT_CYC  ACCESS cycles allowed before the watchdog fires
//                (only used when ROOTH_BUS_TIMEOUT_EN is defined)
//
// Build options
//   ROOTH_BUS_TIMEOUT_EN  when defined, an ACCESS that sees no s_ack within
//                         TIMEOUT_CYC cycles is ended with m_err=1, m_rdata=0.
//                         When undefined, ACCESS waits forever, m_err is 0.
//
// Ports
//   clk        single clock, rising edge
//   rst        synchronous active-high reset
//   m_req      per-master request, held until m_gnt
//   m_we       per-master write enable          (bit i)
//   m_addr     per-master address               ([i*DW +: DW])
//   m_wdata    per-master write data            ([i*DW +: DW])
//   m_be       per-master byte enables          ([i*4 +: 4])
//   m_gnt      one-cycle pulse: request accepted
//   m_rvalid   one-cycle pulse: response valid
//   m_rdata    shared response data, 0 unless m_rvalid
//   m_err      shared error flag, 0 unless m_rvalid
//   s_req      slave request, high for every ACCESS cycle
//   s_we       latched write enable
//   s_addr     latched address
//   s_wdata    latched write data
//   s_be       latched byte enables
//   s_ack      slave completion, only honoured in ACCESS
//   s_rdata    slave read data, valid with s_ack
// -----------------------------------------------------------------------------
module rooth_bus_arb #(
    parameter int unsigned DW          = 32,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic            clk,
    input  logic            rst,

    input  logic [2:0]      m_req,
    input  logic [2:0]      m_we,
    input  logic [3*DW-1:0] m_addr,
    input  logic [3*DW-1:0] m_wdata,
    input  logic [11:0]     m_be,
    output logic [2:0]      m_gnt,
    output logic [2:0]      m_rvalid,
    output logic [DW-1:0]   m_rdata,
    output logic            m_err,

    output logic            s_req,
    output logic            s_we,
    output logic [DW-1:0]   s_addr,
    output logic [DW-1:0]   s_wdata,
    output logic [3:0]      s_be,
    input  logic            s_ack,
    input  logic [DW-1:0]   s_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

    state_e          state_q,  state_d;
    logic [1:0]      last_q,   last_d;    // index of the last granted master
    logic [1:0]      idx_q,    idx_d;     // index of the master being served
    logic            we_q,     we_d;
    logic [DW-1:0]   addr_q,   addr_d;
    logic [DW-1:0]   wdata_q,  wdata_d;
    logic [3:0]      be_q,     be_d;
    logic [2:0]      gnt_q,    gnt_d;
    logic [2:0]      rvalid_q, rvalid_d;
    logic [DW-1:0]   rdata_q,  rdata_d;

`ifdef ROOTH_BUS_TIMEOUT_EN
    localparam int unsigned CNT_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC);
    // Count value seen during the last ACCESS cycle that is allowed to wait.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
`endif

    // -------------------------------------------------------------------------
    // Round-robin winner: search starts just after the last granted master and
    // wraps 2->0. Only meaningful when at least one request bit is set.
    // -------------------------------------------------------------------------
    logic [1:0] win;

    always_comb begin
        // NOTE: every signal written in an always_comb gets a default first so
        // that no path leaves it unassigned and infers a latch.
        win = 2'd0;
        case (last_q)
            2'd0:    win = m_req[1] ? 2'd1 : (m_req[2] ? 2'd2 : 2'd0);
            2'd1:    win = m_req[2] ? 2'd2 : (m_req[0] ? 2'd0 : 2'd1);
            default: win = m_req[0] ? 2'd0 : (m_req[1] ? 2'd1 : 2'd2);
        endcase
    end

    // -------------------------------------------------------------------------
    // Next-state and next-output logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        idx_d    = idx_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        be_d     = be_q;
        // Pulses and response data default to 0 so they are only ever high
        // for the single cycle following the edge that set them.
        gnt_d    = 3'b000;
        rvalid_d = 3'b000;
        rdata_d  = '0;
`ifdef ROOTH_BUS_TIMEOUT_EN
        cnt_d    = cnt_q;
        err_d    = 1'b0;
`endif

        case (state_q)
            ST_IDLE: begin
                if (|m_req) begin
                    idx_d   = win;
                    last_d  = win;
                    we_d    = m_we[win];
                    addr_d  = m_addr[win*DW +: DW];
                    wdata_d = m_wdata[win*DW +: DW];
                    be_d    = m_be[win*4 +: 4];
                    gnt_d   = 3'b001 << win;
                    state_d = ST_ACCESS;
`ifdef ROOTH_BUS_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end

            ST_ACCESS: begin
                // s_ack wins over a watchdog expiry on the same cycle.
                if (s_ack) begin
                    rvalid_d = 3'b001 << idx_q;
                    rdata_d  = s_rdata;
                    state_d  = ST_RESP;
                end
`ifdef ROOTH_BUS_TIMEOUT_EN
                else if (cnt_q == CNT_LAST) begin
                    rvalid_d = 3'b001 << idx_q;
                    err_d    = 1'b1;
                    state_d  = ST_RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end

            ST_RESP: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge value of every other register.
        if (rst) begin
            state_q  <= ST_IDLE;
            // Pointing at master 2 makes master 0 first in line after reset.
            last_q   <= 2'd2;
            idx_q    <= 2'd0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            be_q     <= 4'b0000;
            gnt_q    <= 3'b000;
            rvalid_q <= 3'b000;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            idx_q    <= idx_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            be_q     <= be_d;
            gnt_q    <= gnt_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
        end
    end

`ifdef ROOTH_BUS_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign m_err = err_q;
`else
    // Without the watchdog an access cannot fail.
    assign m_err = 1'b0;

    // TIMEOUT_CYC stays on the parameter list so both builds are drop-in
    // compatible; nothing is generated from it here.
    if (TIMEOUT_CYC == 0) begin : g_timeout_unused
    end
`endif

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign s_req    = (state_q == ST_ACCESS);
    assign s_we     = we_q;
    assign s_addr   = addr_q;
    assign s_wdata  = wdata_q;
    assign s_be     = be_q;

    assign m_gnt    = gnt_q;
    assign m_rvalid = rvalid_q;
    assign m_rdata  = rdata_q;

endmodule

// File: tb/tb_rooth_bus_arb.sv
// -----------------------------------------------------------------------------
// tb_rooth_bus_arb
//
// Self-checking bench for rooth_bus_arb. Expected grants come from a priority
// list model: the list holds the masters in search order and, after a grant,
// is rotated until the winner sits at the back. Expected slave fields and read
// data are captured from the stimulus the bench itself drove.
// -----------------------------------------------------------------------------
module tb_rooth_bus_arb;

    localparam int DW = 32;
    localparam int TO = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic [2:0]      m_req;
    logic [2:0]      m_we;
    logic [3*DW-1:0] m_addr;
    logic [3*DW-1:0] m_wdata;
    logic [11:0]     m_be;
    logic [2:0]      m_gnt;
    logic [2:0]      m_rvalid;
    logic [DW-1:0]   m_rdata;
    logic            m_err;
    logic            s_req;
    logic            s_we;
    logic [DW-1:0]   s_addr;
    logic [DW-1:0]   s_wdata;
    logic [3:0]      s_be;
    logic            s_ack;
    logic [DW-1:0]   s_rdata;

    always #5 clk = ~clk;

    rooth_bus_arb #(
        .DW          (DW),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .m_req    (m_req),
        .m_we     (m_we),
        .m_addr   (m_addr),
        .m_wdata  (m_wdata),
        .m_be     (m_be),
        .m_gnt    (m_gnt),
        .m_rvalid (m_rvalid),
        .m_rdata  (m_rdata),
        .m_err    (m_err),
        .s_req    (s_req),
        .s_we     (s_we),
        .s_addr   (s_addr),
        .s_wdata  (s_wdata),
        .s_be     (s_be),
        .s_ack    (s_ack),
        .s_rdata  (s_rdata)
    );

    int n_total = 0;
    int n_bad   = 0;

    // Search order of the masters; the front is asked first.
    logic [1:0] prio_q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // One clock, then settle away from the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [2:0] oh(input logic [1:0] i);
        return 3'b001 << i;
    endfunction

    function automatic logic [1:0] model_pick(input logic [2:0] req);
        logic [1:0] r;
        r = prio_q[0];
        for (int i = 2; i >= 0; i--) begin
            if (req[prio_q[i]]) r = prio_q[i];
        end
        return r;
    endfunction

    task automatic model_grant(input logic [1:0] w);
        while (prio_q[2] != w) prio_q.push_back(prio_q.pop_front());
    endtask

    task automatic model_reset();
        prio_q = {2'd0, 2'd1, 2'd2};
    endtask

    task automatic rand_fields(input logic [1:0] i);
        m_we[i]              = 1'($urandom);
        m_addr[i*DW +: DW]   = $urandom;
        m_wdata[i*DW +: DW]  = $urandom;
        m_be[i*4 +: 4]       = 4'($urandom);
    endtask

    task automatic check_access(input logic we, input logic [DW-1:0] addr,
                                input logic [DW-1:0] wdata, input logic [3:0] be);
        check("acc_s_req",   64'(s_req),    64'd1);
        check("acc_s_we",    64'(s_we),     64'(we));
        check("acc_s_addr",  64'(s_addr),   64'(addr));
        check("acc_s_wdata", 64'(s_wdata),  64'(wdata));
        check("acc_s_be",    64'(s_be),     64'(be));
        check("acc_rvalid",  64'(m_rvalid), 64'd0);
        check("acc_rdata",   64'(m_rdata),  64'd0);
        check("acc_err",     64'(m_err),    64'd0);
    endtask

    // Runs one access starting from an IDLE cycle with m_req already driven.
    // The winner drops its request after m_gnt; late_req is raised mid-access.
    task automatic run_txn(input int delay, input logic [2:0] late_req,
                           input logic [DW-1:0] ack_data);
        logic [1:0]    w;
        logic          e_we;
        logic [DW-1:0] e_addr;
        logic [DW-1:0] e_wdata;
        logic [3:0]    e_be;
        w       = model_pick(m_req);
        model_grant(w);
        e_we    = m_we[w];
        e_addr  = m_addr[w*DW +: DW];
        e_wdata = m_wdata[w*DW +: DW];
        e_be    = m_be[w*4 +: 4];

        step();
        check("gnt", 64'(m_gnt), 64'(oh(w)));
        check_access(e_we, e_addr, e_wdata, e_be);

        // The winner is free to move on; the latched copy must not follow.
        m_req[w] = 1'b0;
        rand_fields(w);
        m_req    = m_req | late_req;

        for (int k = 0; k <= delay; k++) begin
            if (k > 0) begin
                step();
                check("gnt_once", 64'(m_gnt), 64'd0);
                check_access(e_we, e_addr, e_wdata, e_be);
            end
            s_rdata = (k == delay) ? ack_data : $urandom;
            s_ack   = (k == delay);
        end

        step();
        // s_ack during RESP must be ignored.
        s_ack   = 1'($urandom);
        s_rdata = $urandom;
        check("resp_rvalid", 64'(m_rvalid), 64'(oh(w)));
        check("resp_rdata",  64'(m_rdata),  64'(ack_data));
        check("resp_err",    64'(m_err),    64'd0);
        check("resp_s_req",  64'(s_req),    64'd0);
        check("resp_gnt",    64'(m_gnt),    64'd0);

        step();
        s_ack = 1'b0;
        check("idle_rvalid", 64'(m_rvalid), 64'd0);
        check("idle_rdata",  64'(m_rdata),  64'd0);
        check("idle_s_req",  64'(s_req),    64'd0);
        check("idle_gnt",    64'(m_gnt),    64'd0);
    endtask

    initial begin
        logic [1:0]    w;
        logic [DW-1:0] sd_prev;
        logic [1:0]    exp_order [6];
        int            n_hi;
        int            n_rv;
        bit            seen;

        // ------------------------------------------------------------ reset
        model_reset();
        rst     = 1'b1;
        m_req   = 3'b111;
        m_we    = 3'b111;
        m_addr  = {3{32'hFFFF_FFFF}};
        m_wdata = {3{32'hA5A5_A5A5}};
        m_be    = 12'hFFF;
        s_ack   = 1'b1;
        s_rdata = 32'h1234_5678;
        step();
        step();
        check("rst_s_req",  64'(s_req),    64'd0);
        check("rst_gnt",    64'(m_gnt),    64'd0);
        check("rst_rvalid", 64'(m_rvalid), 64'd0);
        check("rst_rdata",  64'(m_rdata),  64'd0);
        check("rst_err",    64'(m_err),    64'd0);
        check("rst_s_we",   64'(s_we),     64'd0);
        check("rst_s_addr", 64'(s_addr),   64'd0);
        check("rst_s_wdata",64'(s_wdata),  64'd0);
        check("rst_s_be",   64'(s_be),     64'd0);

        // ---------------------------------- all masters, s_ack tied high
        exp_order = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2};
        rst     = 1'b0;
        sd_prev = $urandom;
        s_rdata = sd_prev;
        for (int c = 0; c < 18; c++) begin
            step();
            if (c % 3 == 0) begin
                check("rr_gnt", 64'(m_gnt), 64'(oh(exp_order[c / 3])));
                model_grant(exp_order[c / 3]);
            end else begin
                check("rr_gnt_quiet", 64'(m_gnt), 64'd0);
            end
            if (c % 3 == 1) begin
                check("rr_rvalid", 64'(m_rvalid), 64'(oh(exp_order[c / 3])));
                check("rr_rdata",  64'(m_rdata),  64'(sd_prev));
            end else begin
                check("rr_rvalid_quiet", 64'(m_rvalid), 64'd0);
            end
            sd_prev = $urandom;
            s_rdata = sd_prev;
        end
        m_req = 3'b000;
        s_ack = 1'b0;

        // ------------------------- core data port read with slow slave
        m_we[1]            = 1'b0;
        m_addr[1*DW +: DW] = 32'h1000_0004;
        m_req              = 3'b010;
        run_txn(3, 3'b000, 32'hDEAD_BEEF);

        // -------------- DMA write while the debug master arrives mid-access
        m_we[2]             = 1'b1;
        m_wdata[2*DW +: DW] = 32'h5A5A_5A5A;
        m_be[2*4 +: 4]      = 4'b0011;
        m_req               = 3'b100;
        run_txn(2, 3'b001, 32'h0BAD_F00D);
        run_txn(0, 3'b000, $urandom);

        // ---------------------------------------- reset in mid-access
        rand_fields(2'd1);
        m_req = 3'b010;
        w     = model_pick(m_req);
        step();
        check("abort_gnt",   64'(m_gnt), 64'(oh(w)));
        check("abort_s_req", 64'(s_req), 64'd1);
        rst   = 1'b1;
        m_req = 3'b111;
        step();
        rst = 1'b0;
        model_reset();
        check("abort_s_req_drop", 64'(s_req),    64'd0);
        check("abort_no_rvalid",  64'(m_rvalid), 64'd0);
        check("abort_no_gnt",     64'(m_gnt),    64'd0);
        for (int i = 0; i < 3; i++) rand_fields(2'(i));
        run_txn(1, 3'b000, $urandom);

        // ---------------------------------------------- random traffic
        for (int t = 0; t < 60; t++) begin
            logic [2:0] add;
            add = 3'($urandom_range(1, 7));
            for (int i = 0; i < 3; i++) begin
                if (add[i] && !m_req[i]) rand_fields(2'(i));
            end
            m_req = m_req | add;
            run_txn($urandom_range(0, 4), 3'($urandom), $urandom);
        end

        // --------------------------------------- slave that never answers
        m_req = 3'b001;
        w     = model_pick(m_req);
        model_grant(w);
        s_ack = 1'b0;
        step();
        check("hang_gnt", 64'(m_gnt), 64'(oh(w)));
        m_req = 3'b000;
`ifdef ROOTH_BUS_TIMEOUT_EN
        s_rdata = 32'hFFFF_FFFF;
        n_hi    = 0;
        seen    = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            if (m_rvalid != 3'b000) begin
                seen = 1'b1;
            end else begin
                if (s_req) n_hi++;
                step();
            end
        end
        check("to_rvalid_seen", 64'(seen),     64'd1);
        check("to_s_req_cycles",64'(n_hi),     64'(TO));
        check("to_rvalid",      64'(m_rvalid), 64'(oh(w)));
        check("to_err",         64'(m_err),    64'd1);
        check("to_rdata",       64'(m_rdata),  64'd0);
        check("to_s_req_low",   64'(s_req),    64'd0);
        step();
        check("to_err_clear",   64'(m_err),    64'd0);
        check("to_rvalid_clear",64'(m_rvalid), 64'd0);
`else
        n_hi = 0;
        n_rv = 0;
        for (int c = 0; c < 1000; c++) begin
            if (s_req) n_hi++;
            if (m_rvalid != 3'b000) n_rv++;
            if (c < 999) step();
        end
        check("wait_s_req_cycles", 64'(n_hi), 64'd1000);
        check("wait_no_rvalid",    64'(n_rv), 64'd0);
        s_rdata = 32'hCAFE_0001;
        s_ack   = 1'b1;
        step();
        s_ack = 1'b0;
        check("wait_rvalid", 64'(m_rvalid), 64'(oh(w)));
        check("wait_rdata",  64'(m_rdata),  64'hCAFE_0001);
        check("wait_err",    64'(m_err),    64'd0);
        step();
        check("wait_idle_rvalid", 64'(m_rvalid), 64'd0);
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
